// File: rtl/cache_line_word_streamer_pkg.sv
// Shared widths, types and FSM states for the cache-line word streamer.
// Covers the line/word/offset/mask types and a single-bit-set helper for the last-word flag.
package cache_line_word_streamer_pkg;

  localparam int WORD_WIDTH   = 16;
  localparam int NUM_WORDS    = 8;
  localparam int OFFSET_WIDTH = $clog2(NUM_WORDS);
  localparam int LINE_WIDTH   = WORD_WIDTH * NUM_WORDS;

  typedef logic [WORD_WIDTH-1:0]   lc3b_word;
  typedef logic [OFFSET_WIDTH-1:0] cache_offset;
  typedef logic [LINE_WIDTH-1:0]   cache_line;
  typedef logic [NUM_WORDS-1:0]    cache_mask;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } streamer_state_e;

  // True when exactly one bit of the mask is set.
  function automatic logic mask_is_single(input cache_mask m);
    return (m != '0) && ((m & (m - NUM_WORDS'(1))) == '0);
  endfunction

endpackage

// File: rtl/cache_line_word_streamer_word_mask_scan.sv
// Rotating priority finder: returns the first set mask bit at or after i_base,
// wrapping modulo NUM_WORDS, as both an index and a one-hot vector.
module word_mask_scan
  import cache_line_word_streamer_pkg::*;
(
  input  logic [NUM_WORDS-1:0]    i_mask,
  input  logic [OFFSET_WIDTH-1:0] i_base,
  output logic                    o_found,
  output logic [OFFSET_WIDTH-1:0] o_idx,
  output logic [NUM_WORDS-1:0]    o_onehot
);

  logic [OFFSET_WIDTH-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      // NUM_WORDS is a power of two, so the narrow add wraps for free.
      w_cand = i_base + OFFSET_WIDTH'(k);
      if (!o_found && i_mask[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    o_onehot = o_found ? (NUM_WORDS'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/cache_line_word_streamer.sv
// Captures one cache line plus a word-select mask and streams the selected words
// in circular order from a critical-word offset, one per valid/ready handshake.
module cache_line_word_streamer
  import cache_line_word_streamer_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_line_valid,
  output logic                    o_line_ready,
  input  logic [LINE_WIDTH-1:0]   i_line_data,
  input  logic [NUM_WORDS-1:0]    i_line_mask,
  input  logic [OFFSET_WIDTH-1:0] i_start_offset,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic [WORD_WIDTH-1:0]   o_word_data,
  output logic [OFFSET_WIDTH-1:0] o_word_offset,
  output logic [NUM_WORDS-1:0]    o_word_onehot,
  output logic                    o_word_last,
  output logic                    o_busy
);

  streamer_state_e r_state, w_state_next;
  cache_line       r_line,  w_line_next;
  cache_mask       r_mask,  w_mask_next;
  cache_mask       r_onehot, w_onehot_next;
  cache_offset     r_ptr,   w_ptr_next;

  logic        w_load_found, w_adv_found;
  cache_offset w_load_idx,   w_adv_idx;
  cache_mask   w_load_onehot, w_adv_onehot;
  cache_mask   w_mask_cleared;
  cache_offset w_adv_base;
  lc3b_word    w_word_sel;
  logic        w_busy;

  assign w_mask_cleared = r_mask & ~r_onehot;
  assign w_adv_base     = r_ptr + OFFSET_WIDTH'(1);

  word_mask_scan u_load_scan (
    .i_mask   (i_line_mask),
    .i_base   (i_start_offset),
    .o_found  (w_load_found),
    .o_idx    (w_load_idx),
    .o_onehot (w_load_onehot)
  );

  word_mask_scan u_adv_scan (
    .i_mask   (w_mask_cleared),
    .i_base   (w_adv_base),
    .o_found  (w_adv_found),
    .o_idx    (w_adv_idx),
    .o_onehot (w_adv_onehot)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_line   <= '0;
      r_mask   <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_line   <= w_line_next;
      r_mask   <= w_mask_next;
      r_onehot <= w_onehot_next;
      r_ptr    <= w_ptr_next;
    end
  end

  // An empty mask still consumes the line but never leaves IDLE.
  always_comb begin
    w_state_next  = r_state;
    w_line_next   = r_line;
    w_mask_next   = r_mask;
    w_onehot_next = r_onehot;
    w_ptr_next    = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (i_line_valid) begin
          w_line_next = i_line_data;
          if (w_load_found) begin
            w_mask_next   = i_line_mask;
            w_ptr_next    = w_load_idx;
            w_onehot_next = w_load_onehot;
            w_state_next  = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (i_word_ready) begin
          w_mask_next = w_mask_cleared;
          if (w_adv_found) begin
            w_ptr_next    = w_adv_idx;
            w_onehot_next = w_adv_onehot;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_word_sel = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (r_ptr == OFFSET_WIDTH'(i)) w_word_sel = r_line[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Word outputs read as zero outside STREAM so stale line contents never leak.
  assign w_busy        = (r_state == ST_STREAM);
  assign o_busy        = w_busy;
  assign o_line_ready  = ~w_busy;
  assign o_word_valid  = w_busy;
  assign o_word_data   = w_busy ? w_word_sel : '0;
  assign o_word_offset = w_busy ? r_ptr : '0;
  assign o_word_onehot = w_busy ? r_onehot : '0;
  assign o_word_last   = w_busy && mask_is_single(r_mask);

endmodule

// File: tb/tb_cache_line_word_streamer.sv
// Directed bench for cache_line_word_streamer: a circular-scan model fills a
// scoreboard queue per line, and each emitted word is checked against its head.
module tb_cache_line_word_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_valid;
  logic        line_ready;
  logic [127:0] line_data;
  logic [7:0]  line_mask;
  logic [2:0]  start_offset;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_data;
  logic [2:0]  word_offset;
  logic [7:0]  word_onehot;
  logic        word_last;
  logic        busy;

  typedef struct {
    logic [2:0]  off;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  cache_line_word_streamer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_line_valid   (line_valid),
    .o_line_ready   (line_ready),
    .i_line_data    (line_data),
    .i_line_mask    (line_mask),
    .i_start_offset (start_offset),
    .o_word_valid   (word_valid),
    .i_word_ready   (word_ready),
    .o_word_data    (word_data),
    .o_word_offset  (word_offset),
    .o_word_onehot  (word_onehot),
    .o_word_last    (word_last),
    .o_busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one line for a single accepted cycle and pushes the model's word order.
  task automatic applyStimulus(input logic [7:0] mask, input logic [2:0] start);
    int   waitCnt = 0;
    int   idx;
    exp_t e;
    while (!line_ready && waitCnt < 20) begin
      nextCycle();
      waitCnt++;
    end
    checkOutput("line_ready_wait", {31'd0, line_ready}, 32'd1);
    for (int i = 0; i < 8; i++) line_data[16*i +: 16] = 16'h1111 * 16'(i);
    line_mask    = mask;
    start_offset = start;
    line_valid   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(start) + k) % 8;
      if (mask[idx]) begin
        e.off  = 3'(idx);
        e.data = 16'h1111 * 16'(idx);
        e.last = 1'b0;
        expQ.push_back(e);
      end
    end
    if (expQ.size() > 0) expQ[expQ.size()-1].last = 1'b1;
    nextCycle();
    line_valid = 1'b0;
  endtask

  // Consumes the queued words; ready is dropped for holdCycles while holdOff is shown.
  task automatic drainLine(input string tag, input int holdOff, input int holdCycles);
    int   cycles = 0;
    int   holdLeft = holdCycles;
    exp_t e;
    while (expQ.size() > 0 && cycles < 60) begin
      e = expQ[0];
      checkOutput({tag, "_valid"},  {31'd0, word_valid}, 32'd1);
      checkOutput({tag, "_offset"}, {29'd0, word_offset}, {29'd0, e.off});
      checkOutput({tag, "_data"},   {16'd0, word_data}, {16'd0, e.data});
      checkOutput({tag, "_onehot"}, {24'd0, word_onehot}, {24'd0, 8'(1) << e.off});
      checkOutput({tag, "_last"},   {31'd0, word_last}, {31'd0, e.last});
      if (holdLeft > 0 && int'(e.off) == holdOff) begin
        word_ready = 1'b0;
        holdLeft--;
      end else begin
        word_ready = 1'b1;
        void'(expQ.pop_front());
      end
      nextCycle();
      cycles++;
    end
    word_ready = 1'b1;
    checkOutput({tag, "_leftover"},   expQ.size(), 32'd0);
    checkOutput({tag, "_line_ready"}, {31'd0, line_ready}, 32'd1);
    checkOutput({tag, "_idle_valid"}, {31'd0, word_valid}, 32'd0);
    checkOutput({tag, "_idle_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst          = 1'b1;
    line_valid   = 1'b0;
    line_data    = '0;
    line_mask    = '0;
    start_offset = '0;
    word_ready   = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("rst_line_ready",  {31'd0, line_ready}, 32'd1);
    checkOutput("rst_word_valid",  {31'd0, word_valid}, 32'd0);
    checkOutput("rst_word_last",   {31'd0, word_last}, 32'd0);
    checkOutput("rst_busy",        {31'd0, busy}, 32'd0);
    checkOutput("rst_word_data",   {16'd0, word_data}, 32'd0);
    checkOutput("rst_word_offset", {29'd0, word_offset}, 32'd0);
    checkOutput("rst_word_onehot", {24'd0, word_onehot}, 32'd0);
    rst = 1'b0;
    nextCycle();

    $display("[TB] full line from offset 0");
    applyStimulus(8'hFF, 3'd0);
    drainLine("full", -1, 0);

    $display("[TB] critical word first with wrap");
    applyStimulus(8'hFF, 3'd5);
    drainLine("wrap", -1, 0);

    $display("[TB] sparse mask");
    applyStimulus(8'h24, 3'd6);
    drainLine("sparse", -1, 0);

    $display("[TB] backpressure on offset 3");
    applyStimulus(8'hFF, 3'd0);
    drainLine("bp", 3, 3);

    $display("[TB] empty mask");
    applyStimulus(8'h00, 3'd3);
    for (int c = 0; c < 3; c++) begin
      checkOutput("empty_valid",      {31'd0, word_valid}, 32'd0);
      checkOutput("empty_line_ready", {31'd0, line_ready}, 32'd1);
      checkOutput("empty_busy",       {31'd0, busy}, 32'd0);
      nextCycle();
    end

    $display("[TB] reset mid-stream");
    applyStimulus(8'hFF, 3'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("rstmid_offset", {29'd0, word_offset}, {29'd0, expQ[0].off});
      checkOutput("rstmid_data",   {16'd0, word_data}, {16'd0, expQ[0].data});
      void'(expQ.pop_front());
      nextCycle();
    end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    expQ.delete();
    checkOutput("rstmid_valid",      {31'd0, word_valid}, 32'd0);
    checkOutput("rstmid_line_ready", {31'd0, line_ready}, 32'd1);
    checkOutput("rstmid_last",       {31'd0, word_last}, 32'd0);
    applyStimulus(8'h81, 3'd7);
    drainLine("after_rst", -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
